// File: rtl/float_pkg.sv
// Shared float format constants and helpers.
// Used by the float multiplier and float adders.
package float_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  function automatic int word_w(
    input int ew,
    input int mw
  );
    return 1 + ew + mw;
  endfunction

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  localparam int W_DEF    = word_w(EXP_W_DEF, MAN_W_DEF);
  localparam int BIAS_DEF = bias(EXP_W_DEF);

endpackage

// File: rtl/float_round_pack.sv
// S3 of the float multiplier: round, saturate, pack.
// In: zero/sign/exp/man/guard/sticky. Out: word, ovf, unf.
module float_round_pack
  import float_pkg::*;
#(
  parameter int EXP_W     = EXP_W_DEF,
  parameter int MAN_W     = MAN_W_DEF,
  parameter int ROUND_RNE = int'(RND_RNE),
  localparam int W        = word_w(EXP_W, MAN_W),
  localparam int EW2      = EXP_W + 2
) (
  input  logic                  zero_i,
  input  logic                  sign_i,
  input  logic signed [EW2-1:0] exp_i,
  input  logic [MAN_W-1:0]      man_i,
  input  logic                  guard_i,
  input  logic                  sticky_i,
  output logic [W-1:0]          word_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  localparam logic RNE = (ROUND_RNE != 0);

  localparam logic signed [EW2-1:0] EMAX =
    EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EMIN =
    EW2'(1);

  logic               inc;
  logic [MAN_W:0]     man_sum;
  logic [MAN_W-1:0]   man_r;
  logic signed [EW2-1:0] exp_r;

  always_comb begin
    inc = RNE & guard_i & (sticky_i | man_i[0]);
    man_sum = {1'b0, man_i} + {{MAN_W{1'b0}}, inc};
    // carry-out leaves the low bits zero: 1.11..1 + ulp = 10.0..0
    man_r = man_sum[MAN_W-1:0];
    exp_r = exp_i
          + $signed({{(EW2-1){1'b0}}, man_sum[MAN_W]});
  end

  always_comb begin
    word_o = '0;
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    if (zero_i) begin
      word_o = '0;
    end else if (exp_r > EMAX) begin
      word_o = {sign_i, {(W-1){1'b1}}};
      ovf_o  = 1'b1;
    end else if (exp_r < EMIN) begin
      unf_o  = 1'b1;
    end else begin
      word_o = {sign_i, exp_r[EXP_W-1:0], man_r};
    end
  end

endmodule

// File: rtl/float_mult_pipe.sv
// 3-stage float multiplier: unpack/mul, normalise, round/pack.
// Ports: clk, reset(n), in valid/ready, a/b, out valid/ready, product, ovf, unf.
module float_mult_pipe
  import float_pkg::*;
#(
  parameter int EXP_W     = EXP_W_DEF,
  parameter int MAN_W     = MAN_W_DEF,
  parameter int ROUND_RNE = int'(RND_RNE),
  localparam int W        = word_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] float_a,
  input  logic [W-1:0] float_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         ovf,
  output logic         unf
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;

  localparam logic signed [EW2-1:0] BIAS_E =
    EW2'(bias(EXP_W));
  localparam logic signed [EW2-1:0] ONE_E =
    EW2'(1);

  logic adv;

  logic                  v1_q, v1_d;
  logic                  z1_q, z1_d;
  logic                  s1_q, s1_d;
  logic signed [EW2-1:0] e1_q, e1_d;
  logic [PW-1:0]         p1_q, p1_d;

  logic                  v2_q, v2_d;
  logic                  z2_q, z2_d;
  logic                  s2_q, s2_d;
  logic signed [EW2-1:0] e2_q, e2_d;
  logic [MAN_W-1:0]      m2_q, m2_d;
  logic                  g2_q, g2_d;
  logic                  t2_q, t2_d;

  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          product_q, product_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [W-1:0]          rp_word;
  logic                  rp_ovf;
  logic                  rp_unf;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // S1: unpack and multiply hidden-bit mantissas
  always_comb begin
    v1_d = v1_q;
    z1_d = z1_q;
    s1_d = s1_q;
    e1_d = e1_q;
    p1_d = p1_q;
    if (adv) begin
      v1_d = in_valid;
      z1_d = (float_a[W-2:0] == '0)
          || (float_b[W-2:0] == '0);
      s1_d = float_a[W-1] ^ float_b[W-1];
      e1_d = $signed({2'b00, float_a[W-2:MAN_W]})
           + $signed({2'b00, float_b[W-2:MAN_W]})
           - BIAS_E;
      p1_d = {1'b1, float_a[MAN_W-1:0]}
           * {1'b1, float_b[MAN_W-1:0]};
    end
  end

  // S2: product is 1.x or 1x.x; align to 1.x
  always_comb begin
    v2_d = v2_q;
    z2_d = z2_q;
    s2_d = s2_q;
    e2_d = e2_q;
    m2_d = m2_q;
    g2_d = g2_q;
    t2_d = t2_q;
    if (adv) begin
      v2_d = v1_q;
      z2_d = z1_q;
      s2_d = s1_q;
      if (p1_q[PW-1]) begin
        e2_d = e1_q + ONE_E;
        m2_d = p1_q[PW-2 -: MAN_W];
        g2_d = p1_q[MAN_W];
        t2_d = |p1_q[MAN_W-1:0];
      end else begin
        e2_d = e1_q;
        m2_d = p1_q[PW-3 -: MAN_W];
        g2_d = p1_q[MAN_W-1];
        t2_d = |p1_q[MAN_W-2:0];
      end
    end
  end

  float_round_pack #(
    .EXP_W     (EXP_W),
    .MAN_W     (MAN_W),
    .ROUND_RNE (ROUND_RNE)
  ) u_round_pack (
    .zero_i   (z2_q),
    .sign_i   (s2_q),
    .exp_i    (e2_q),
    .man_i    (m2_q),
    .guard_i  (g2_q),
    .sticky_i (t2_q),
    .word_o   (rp_word),
    .ovf_o    (rp_ovf),
    .unf_o    (rp_unf)
  );

  // S3: output register, held while stalled
  always_comb begin
    out_valid_d = out_valid_q;
    product_d   = product_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (adv) begin
      out_valid_d = v2_q;
      product_d   = rp_word;
      ovf_d       = rp_ovf & v2_q;
      unf_d       = rp_unf & v2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      z1_q        <= 1'b0;
      s1_q        <= 1'b0;
      e1_q        <= '0;
      p1_q        <= '0;
      v2_q        <= 1'b0;
      z2_q        <= 1'b0;
      s2_q        <= 1'b0;
      e2_q        <= '0;
      m2_q        <= '0;
      g2_q        <= 1'b0;
      t2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      z1_q        <= z1_d;
      s1_q        <= s1_d;
      e1_q        <= e1_d;
      p1_q        <= p1_d;
      v2_q        <= v2_d;
      z2_q        <= z2_d;
      s2_q        <= s2_d;
      e2_q        <= e2_d;
      m2_q        <= m2_d;
      g2_q        <= g2_d;
      t2_q        <= t2_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_float_mult_pipe.sv
// Bench for float_mult_pipe: RNE and truncating instances,
// scoreboard queue of expected results, backpressure and reset.
module tb_float_mult_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] float_a;
  logic [15:0] float_b;

  logic        in_ready, out_valid, ovf, unf;
  logic [15:0] product;
  logic        in_ready_t, out_valid_t, ovf_t, unf_t;
  logic [15:0] product_t;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] p;
    logic        o;
    logic        u;
    logic [15:0] pt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  float_mult_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_a   (float_a),
    .float_b   (float_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf),
    .unf       (unf)
  );

  float_mult_pipe #(.ROUND_RNE(0)) dut_t (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_t),
    .float_a   (float_a),
    .float_b   (float_b),
    .out_valid (out_valid_t),
    .out_ready (out_ready),
    .product   (product_t),
    .ovf       (ovf_t),
    .unf       (unf_t)
  );

  // Reference: exact integer product, then round by remainder
  function automatic logic [17:0] mdl(
    input logic [15:0] a,
    input logic [15:0] b,
    input bit          rne
  );
    longint pr, m, rem, half;
    int     e, sh;
    logic   sg;
    sg = a[15] ^ b[15];
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0)
      return 18'd0;
    pr = longint'({1'b1, a[9:0]})
       * longint'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (pr >= (longint'(1) << 21)) begin
      sh = 11;
      e++;
    end else begin
      sh = 10;
    end
    m    = pr >> sh;
    rem  = pr - (m << sh);
    half = longint'(1) << (sh - 1);
    if (rne && (rem > half || (rem == half && m[0])))
      m++;
    if (m == 2048) begin
      m = 1024;
      e++;
    end
    if (e > 31) return {sg, 15'h7FFF, 2'b10};
    if (e < 1)  return {16'h0000, 2'b01};
    return {sg, 5'(e), 10'(m - 1024), 2'b00};
  endfunction

  task automatic run_one(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] ep,
    input logic        eo,
    input logic        eu,
    input logic [15:0] et,
    input string       name
  );
    exp_t e;
    sb.push_back('{p: ep, o: eo, u: eu, pt: et});
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    float_a   = a;
    float_b   = b;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1",
               name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early: out_valid=%b at edge %0d want 0",
                 name, out_valid, k);
      end
      @(posedge clk);
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: out_valid=%b want 1",
               name, out_valid);
    end
    checks++;
    if (product !== e.p || ovf !== e.o || unf !== e.u) begin
      errors++;
      $display("FAIL %s rne: got %h o%b u%b want %h o%b u%b",
               name, product, ovf, unf, e.p, e.o, e.u);
    end
    checks++;
    if (out_valid_t !== 1'b1 || product_t !== e.pt) begin
      errors++;
      $display("FAIL %s trunc: got v%b %h want v1 %h",
               name, out_valid_t, product_t, e.pt);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    float_a   = '0;
    float_b   = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || product !== 16'h0 ||
        ovf !== 1'b0 || unf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: v%b p%h o%b u%b r%b want 0 0 0 0 1",
               out_valid, product, ovf, unf, in_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: r%b v%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_defaults();
    run_one(16'h3C00, 16'h3C00, 16'h3C00, 0, 0,
            16'h3C00, "one_x_one");
    run_one(16'h3E00, 16'h3E00, 16'h4080, 0, 0,
            16'h4080, "1p5_sq");
    run_one(16'hBC00, 16'h4000, 16'hC000, 0, 0,
            16'hC000, "neg_x_two");
  endtask

  task automatic test_rounding();
    run_one(16'h3C01, 16'h3E00, 16'h3E02, 0, 0,
            16'h3E01, "round");
  endtask

  task automatic test_limits();
    run_one(16'h7800, 16'h7800, 16'h7FFF, 1, 0,
            16'h7FFF, "overflow");
    run_one(16'h0400, 16'h0400, 16'h0000, 0, 1,
            16'h0000, "underflow");
    run_one(16'h8000, 16'h4000, 16'h0000, 0, 0,
            16'h0000, "neg_zero");
  endtask

  task automatic stream(
    input int    n,
    input bit    rand_ready,
    input string name
  );
    logic [15:0] ra[16];
    logic [15:0] rb[16];
    logic [15:0] hp;
    logic        ho, hu, held;
    logic [17:0] r, rt;
    exp_t        e;
    int          sent, got, cyc;
    for (int i = 0; i < n; i++) begin
      ra[i] = {1'($urandom), 5'($urandom_range(8, 22)),
               10'($urandom)};
      rb[i] = {1'($urandom), 5'($urandom_range(8, 22)),
               10'($urandom)};
      if ($urandom_range(0, 7) == 0) rb[i] = 16'h8000;
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    held = 1'b0;
    hp   = '0;
    ho   = 1'b0;
    hu   = 1'b0;
    while (got < n && cyc < 600) begin
      @(negedge clk);
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || product !== hp ||
            ovf !== ho || unf !== hu) begin
          errors++;
          $display("FAIL %s stall: v%b %h o%b u%b want 1 %h o%b u%b",
                   name, out_valid, product, ovf, unf, hp, ho, hu);
        end
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        in_valid = 1'b1;
        float_a  = ra[sent];
        float_b  = rb[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra: got %h want none", name, product);
        end else begin
          e = sb.pop_front();
          if (product !== e.p || ovf !== e.o || unf !== e.u ||
              product_t !== e.pt) begin
            errors++;
            $display("FAIL %s data %0d: got %h/%h o%b u%b want %h/%h o%b u%b",
                     name, got, product, product_t, ovf, unf,
                     e.p, e.pt, e.o, e.u);
          end
        end
        got++;
      end
      held = out_valid && !out_ready;
      hp   = product;
      ho   = ovf;
      hu   = unf;
      if (in_valid && in_ready) begin
        r  = mdl(float_a, float_b, 1'b1);
        rt = mdl(float_a, float_b, 1'b0);
        sb.push_back('{p: r[17:2], o: r[1], u: r[0],
                       pt: rt[17:2]});
        sent++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != n || sb.size() != 0) begin
      errors++;
      $display("FAIL %s count: got %0d left %0d want %0d 0",
               name, got, sb.size(), n);
    end
    if (!rand_ready) begin
      checks++;
      if (cyc != n + 3) begin
        errors++;
        $display("FAIL %s throughput: %0d cycles want %0d",
                 name, cyc, n + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    stream(6, 1'b0, "back_to_back");
  endtask

  task automatic test_backpressure();
    stream(8, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      float_a  = 16'h3C00 + 16'(i);
      float_b  = 16'h4000;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid inflight: out_valid=%b want 1",
               out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        product !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid async: v%b r%b p%h want 0 1 0000",
               out_valid, in_ready, product);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid stale: out_valid=%b cycle %0d want 0",
                 out_valid, k);
      end
    end
    sb.delete();
    run_one(16'h3C00, 16'h4000, 16'h4000, 0, 0,
            16'h4000, "after_reset");
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_rounding();
    test_limits();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
